// File: rtl/gerador_sequencia.sv
// rtl/gerador_sequencia.sv - counting-sequence source 0..CONST over valid/ready, done after PASSES wraps
module gerador_sequencia #(
    parameter int WIDTH  = 4,
    parameter int CONST  = 10,
    parameter int PASSES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             match,
    output logic             busy,
    output logic             done
);

    localparam int PW = $clog2(PASSES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CONST_V   = WIDTH'(CONST);
    localparam logic [PW-1:0]    LAST_PASS = PW'(PASSES - 1);

    generate
        if (CONST < 0 || CONST >= (1 << WIDTH) || PASSES < 1) begin : g_bad_params
            $error("gerador_sequencia: CONST must fit in WIDTH bits and PASSES must be >= 1");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic             xfer;

    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out       = out_q;
    assign match     = out_valid && (out_q == CONST_V);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (load) out_d = load_val;
                if (start) begin
                    state_d = S_RUN;
                    pass_d  = '0;
                end
            end
            S_RUN: begin
                if (stop) state_d = S_IDLE;
                if (xfer) begin
                    if (out_q == CONST_V) begin
                        out_d  = '0;
                        pass_d = pass_q + 1'b1;
                        // Final wrap wins over a simultaneous stop.
                        if (pass_q == LAST_PASS) state_d = S_DONE;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                out_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                out_d   = '0;
                pass_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_gerador_sequencia.sv
// tb/tb_gerador_sequencia.sv - directed self-checking bench for gerador_sequencia
module tb_gerador_sequencia;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, load, out_ready;
    logic [3:0] load_val;
    logic       out_valid, match, busy, done;
    logic [3:0] out;

    int checks = 0;
    int errors = 0;

    gerador_sequencia #(.WIDTH(4), .CONST(10), .PASSES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .out_ready(out_ready), .out_valid(out_valid),
        .out(out), .match(match), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic ld, input logic [3:0] lv);
        @(negedge clk);
        start = 1'b1; load = ld; load_val = lv;
        @(negedge clk);
        start = 1'b0; load = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1.
    task automatic stream(input string tag, input int mode, input logic [3:0] first,
                          input int exp_xfers, input bit stop_at_end);
        logic [3:0] exp_v;
        int xfers, wraps;
        bit seen_done;
        exp_v = first; xfers = 0; wraps = 0; seen_done = 0;
        for (int i = 0; i < 200; i++) begin
            out_ready = (mode == 0) ? 1'b1 : ((i % 4) == 0 || (i % 4) == 3);
            stop = stop_at_end && out_valid && (exp_v == 4'd10) && (wraps == 1);
            if (done) begin
                chk({tag, "_done_valid"}, out_valid, 0);
                chk({tag, "_done_busy"}, busy, 0);
                chk({tag, "_xfers"}, xfers, exp_xfers);
                seen_done = 1;
                break;
            end
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_out"}, out, exp_v);
            chk({tag, "_match"}, match, exp_v == 4'd10);
            if (out_ready) begin
                xfers++;
                if (exp_v == 4'd10) begin
                    exp_v = 4'd0;
                    wraps++;
                end else begin
                    exp_v = exp_v + 4'd1;
                end
            end
            @(negedge clk);
        end
        stop = 1'b0;
        chk({tag, "_done_seen"}, seen_done, 1);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_out"}, out, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b1; stop = 1'b0; load = 1'b0; load_val = 4'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);

        // Full run, always ready
        do_start(1'b0, 4'd0);
        stream("full", 0, 4'd0, 22, 1'b0);

        // Backpressure
        do_start(1'b0, 4'd0);
        stream("bp", 1, 4'd0, 22, 1'b0);

        // Load 13 then start separately
        @(negedge clk);
        load = 1'b1; load_val = 4'd13;
        @(negedge clk);
        load = 1'b0;
        chk("load_idle_out", out, 13);
        chk("load_idle_valid", out_valid, 0);
        do_start(1'b0, 4'd0);
        stream("load13", 0, 4'd13, 25, 1'b0);

        // Stop together with transfer of 5 in the second pass
        do_start(1'b0, 4'd0);
        out_ready = 1'b1;
        n = 0;
        while (n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("stop_pre_out", out, 5);
        chk("stop_pre_valid", out_valid, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_valid", out_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_out", out, 6);
        chk("stop_done", done, 0);
        do_start(1'b0, 4'd0);
        stream("resume", 0, 4'd6, 16, 1'b0);

        // load+start together, stop on the final CONST transfer
        do_start(1'b1, 4'd3);
        stream("ldst_stop", 0, 4'd3, 19, 1'b1);

        // Reset asynchronously in the middle of a run
        do_start(1'b0, 4'd0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_out", out, 4);
        #2 rst = 1'b1; start = 1'b1;
        #1;
        chk("arst_out", out, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", out_valid, 0);
        chk("arst_hold_out", out, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
